// File: rtl/tinker_cpu.sv
// Tinker ISA integer subset: multi-cycle 64-bit core.
// Unified byte memory lives in the "memory" instance.
module tinker_mem #(
  parameter int MEM_SIZE = 524288,
  parameter int AW       = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic [AW-1:0] iaddr,
  output logic [31:0]   inst,
  input  logic [AW-1:0] daddr,
  output logic [63:0]   rdata,
  input  logic          we,
  input  logic [63:0]   wdata
);
  logic [7:0] bytes [0:MEM_SIZE-1];

  always_comb begin
    inst  = '0;
    rdata = '0;
    for (int k = 0; k < 4; k++)
      inst[8*k +: 8] = bytes[iaddr + AW'(k)];
    for (int k = 0; k < 8; k++)
      rdata[8*k +: 8] = bytes[daddr + AW'(k)];
  end

  // Plain always: the array is also preloaded hierarchically.
  always @(posedge clk)
    if (we)
      for (int k = 0; k < 8; k++)
        bytes[daddr + AW'(k)] <= wdata[8*k +: 8];
endmodule

module tinker_cpu #(
  parameter int          MEM_SIZE = 524288,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        halt,
  input  logic        in_signal,
  input  logic [63:0] in_data,
  output logic        out_signal,
  output logic [63:0] out_data
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [63:0] TOP = 64'(MEM_SIZE);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM_WB, HALTED
  } state_t;

  state_t state, state_nx;

  logic [63:0] regs [32];
  logic [63:0] pc, a, b, d;
  logic [63:0] res, npc, ea, sdata;
  logic [31:0] ir, inst;
  logic [63:0] rdata;

  logic [4:0]  op, rdi, rsi, rti;
  logic [11:0] lit;
  logic [63:0] zl, sl, sp;

  logic [63:0] alu, nxt, eaddr, sd;
  logic wr, ld, ldpc, st, hlt, outp;
  logic ifault, dfault, stop;
  logic unused_ok;

  assign op  = ir[31:27];
  assign rdi = ir[26:22];
  assign rsi = ir[21:17];
  assign rti = ir[16:12];
  assign lit = ir[11:0];
  assign zl  = {52'd0, lit};
  assign sl  = {{52{lit[11]}}, lit};
  assign sp  = regs[31];

  assign ifault = pc > TOP - 64'd4;
  assign dfault = (ld | st) && (ea > TOP - 64'd8);
  assign stop   = hlt | dfault;
  assign halt   = (state == HALTED);
  assign unused_ok = in_signal;

  tinker_mem #(.MEM_SIZE(MEM_SIZE)) memory (
    .clk   (clk),
    .iaddr (pc[AW-1:0]),
    .inst  (inst),
    .daddr (ea[AW-1:0]),
    .rdata (rdata),
    .we    (state == MEM_WB && st && !dfault),
    .wdata (sdata)
  );

  always_comb begin
    alu = '0; nxt = pc + 64'd4; eaddr = '0; sd = '0;
    wr = 1'b0; ld = 1'b0; ldpc = 1'b0; st = 1'b0;
    hlt = 1'b0; outp = 1'b0;
    case (op)
      5'h00: begin alu = a & b; wr = 1'b1; end
      5'h01: begin alu = a | b; wr = 1'b1; end
      5'h02: begin alu = a ^ b; wr = 1'b1; end
      5'h03: begin alu = ~a; wr = 1'b1; end
      5'h04: begin alu = a >> b[5:0]; wr = 1'b1; end
      5'h05: begin alu = d >> lit[5:0]; wr = 1'b1; end
      5'h06: begin alu = a << b[5:0]; wr = 1'b1; end
      5'h07: begin alu = d << lit[5:0]; wr = 1'b1; end
      5'h08: nxt = d;
      5'h09: nxt = pc + d;
      5'h0A: nxt = pc + sl;
      5'h0B: if (a != '0) nxt = d;
      5'h0C: begin
        eaddr = sp - 64'd8; st = 1'b1;
        sd = pc + 64'd4; nxt = d;
      end
      5'h0D: begin
        eaddr = sp - 64'd8; ld = 1'b1; ldpc = 1'b1;
      end
      5'h0E: if ($signed(a) > $signed(b)) nxt = d;
      5'h0F: begin
        if (lit == 12'd3) begin
          alu = in_data; wr = 1'b1;
        end else if (lit == 12'd4) outp = 1'b1;
        else hlt = 1'b1;
      end
      5'h10: begin eaddr = a + sl; ld = 1'b1; wr = 1'b1; end
      5'h11: begin alu = a; wr = 1'b1; end
      5'h12: begin alu = {d[63:12], lit}; wr = 1'b1; end
      5'h13: begin eaddr = d + sl; st = 1'b1; sd = a; end
      5'h18: begin alu = a + b; wr = 1'b1; end
      5'h19: begin alu = d + zl; wr = 1'b1; end
      5'h1A: begin alu = a - b; wr = 1'b1; end
      5'h1B: begin alu = d - zl; wr = 1'b1; end
      5'h1C: begin alu = a * b; wr = 1'b1; end
      5'h1D: begin
        alu = (b == '0) ? '0 : a / b; wr = 1'b1;
      end
      default: hlt = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:   state_nx = ifault ? HALTED : DECODE;
      DECODE:  state_nx = EXECUTE;
      EXECUTE: state_nx = MEM_WB;
      MEM_WB:  state_nx = stop ? HALTED : FETCH;
      default: state_nx = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 31; i++) regs[i] <= '0;
      regs[31] <= TOP;
      ir <= '0; a <= '0; b <= '0; d <= '0;
      res <= '0; npc <= '0; ea <= '0; sdata <= '0;
      out_signal <= 1'b0;
      out_data <= '0;
    end else begin
      out_signal <= 1'b0;
      case (state)
        FETCH: ir <= inst;
        DECODE: begin
          a <= regs[rsi];
          b <= regs[rti];
          d <= regs[rdi];
        end
        EXECUTE: begin
          res <= alu; npc <= nxt;
          ea <= eaddr; sdata <= sd;
          if (outp) begin
            out_signal <= 1'b1;
            out_data <= a;
          end
        end
        MEM_WB: if (!stop) begin
          if (wr) regs[rdi] <= ld ? rdata : res;
          pc <= ldpc ? rdata : npc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tinker_cpu.sv
// Directed bench for tinker_cpu: single-op vector table
// plus hand-built programs for control flow and faults.
module tb_tinker_cpu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt, in_signal, out_signal;
  logic [63:0] in_data, out_data;

  always #5 clk = ~clk;

  tinker_cpu dut (
    .clk(clk), .reset(reset), .halt(halt),
    .in_signal(in_signal), .in_data(in_data),
    .out_signal(out_signal), .out_data(out_data)
  );

  typedef struct {
    int          op;
    logic [63:0] a, b, d;
    int          l;
    logic [63:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;
  logic [63:0] out_log [$];
  logic [63:0] pa;

  always @(negedge clk)
    if (reset && out_signal) out_log.push_back(out_data);

  function automatic logic [31:0] enc(
    input int op, input int rd, input int rs,
    input int rt, input int l);
    return {op[4:0], rd[4:0], rs[4:0], rt[4:0], l[11:0]};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr64(input logic [63:0] ad,
                      input logic [63:0] v);
    for (int k = 0; k < 8; k++)
      dut.memory.bytes[ad + 64'(k)] = v[8*k +: 8];
  endtask

  function automatic logic [63:0] rd64(input logic [63:0] ad);
    logic [63:0] v;
    for (int k = 0; k < 8; k++)
      v[8*k +: 8] = dut.memory.bytes[ad + 64'(k)];
    return v;
  endfunction

  task automatic put(input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      dut.memory.bytes[pa + 64'(k)] = w[8*k +: 8];
    pa += 64'd4;
  endtask

  task automatic start();
    reset = 1'b0;
    out_log.delete();
    for (int i = 0; i < 'h1100; i++) dut.memory.bytes[i] = 8'h00;
    pa = '0;
  endtask

  task automatic go();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic run(input int bound, output int cyc);
    cyc = 0;
    while (!halt && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc, bad;
    in_signal = 1'b0;
    in_data = '0;

    vecs[0]  = '{5'h18, 64'd5, 64'd7, 64'd0, 0, 64'd12, "add"};
    vecs[1]  = '{5'h1A, 64'd3, 64'd5, 64'd0, 0,
                 64'hFFFF_FFFF_FFFF_FFFE, "sub_wrap"};
    vecs[2]  = '{5'h1C, 64'h1_0000_0000, 64'h1_0000_0003,
                 64'd0, 0, 64'h3_0000_0000, "mul_low"};
    vecs[3]  = '{5'h1D, 64'd100, 64'd7, 64'd0, 0, 64'd14, "div"};
    vecs[4]  = '{5'h1D, 64'd100, 64'd0, 64'd9, 0, 64'd0, "div0"};
    vecs[5]  = '{5'h00, 64'hF0F0, 64'hFF00, 64'd0, 0,
                 64'hF000, "and"};
    vecs[6]  = '{5'h01, 64'hF0F0, 64'h0F00, 64'd0, 0,
                 64'hFFF0, "or"};
    vecs[7]  = '{5'h02, 64'hFF, 64'h0F, 64'd0, 0, 64'hF0, "xor"};
    vecs[8]  = '{5'h03, 64'd0, 64'd0, 64'd0, 0,
                 64'hFFFF_FFFF_FFFF_FFFF, "not"};
    vecs[9]  = '{5'h04, 64'h8000_0000_0000_0000, 64'h43,
                 64'd0, 0, 64'h1000_0000_0000_0000, "shftr"};
    vecs[10] = '{5'h06, 64'd1, 64'd63, 64'd0, 0,
                 64'h8000_0000_0000_0000, "shftl"};
    vecs[11] = '{5'h05, 64'd0, 64'd0, 64'h100, 4, 64'h10, "shftri"};
    vecs[12] = '{5'h07, 64'd0, 64'd0, 64'd1, 8, 64'h100, "shftli"};
    vecs[13] = '{5'h19, 64'd0, 64'd0, 64'd10, 'hFFF,
                 64'd4105, "addi_zext"};
    vecs[14] = '{5'h1B, 64'd0, 64'd0, 64'd0, 1,
                 64'hFFFF_FFFF_FFFF_FFFF, "subi_wrap"};
    vecs[15] = '{5'h11, 64'h1234, 64'd0, 64'd0, 0, 64'h1234, "mov"};
    vecs[16] = '{5'h12, 64'd0, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA,
                 'h123, 64'hAAAA_AAAA_AAAA_A123, "movl"};

    // reset values, memory untouched by reset
    dut.memory.bytes[32'h300] = 8'hA5;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halt", {63'd0, halt}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_signal", {63'd0, out_signal}, 64'd0);
    chk("rst_r31", dut.regs[31], 64'd524288);
    chk("rst_pc", dut.pc, 64'd0);
    chk("rst_mem", {56'd0, dut.memory.bytes[32'h300]}, 64'hA5);

    // single-op table through load/op/store
    for (int i = 0; i < NV; i++) begin
      start();
      wr64('h200, vecs[i].a);
      wr64('h208, vecs[i].b);
      wr64('h210, vecs[i].d);
      wr64('h218, 64'h5A5A_5A5A_5A5A_5A5A);
      put(enc('h10, 1, 0, 0, 'h200));
      put(enc('h10, 2, 0, 0, 'h208));
      put(enc('h10, 3, 0, 0, 'h210));
      put(enc(vecs[i].op, 3, 1, 2, vecs[i].l));
      put(enc('h13, 0, 3, 0, 'h218));
      put(enc('h0F, 0, 0, 0, 0));
      go();
      run(100, cyc);
      chk(vecs[i].name, rd64('h218), vecs[i].exp);
    end

    // basic add program
    start();
    put(enc('h12, 1, 0, 0, 5));
    put(enc('h12, 2, 0, 0, 7));
    put(enc('h18, 3, 1, 2, 0));
    put(enc('h0F, 0, 3, 0, 4));
    put(enc('h0F, 0, 0, 0, 0));
    go();
    run(40, cyc);
    chk("add_halt_in_20", {63'd0, halt && cyc <= 20}, 64'd1);
    chk("add_out_data", out_data, 64'd12);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (!halt || out_data !== 64'd12) bad++;
    end
    chk("add_hold", 64'(bad), 64'd0);
    chk("add_pulses", 64'(out_log.size()), 64'd1);

    // call / return
    start();
    put(enc('h12, 4, 0, 0, 'h100));
    put(enc('h07, 4, 0, 0, 4));
    put(enc('h11, 31, 4, 0, 0));
    put(enc('h12, 5, 0, 0, 'h40));
    put(enc('h12, 6, 0, 0, 'hCD));
    put(enc('h0C, 5, 0, 0, 0));
    put(enc('h0F, 0, 6, 0, 4));
    put(enc('h0F, 0, 0, 0, 0));
    pa = 64'h40;
    put(enc('h12, 7, 0, 0, 'hAB));
    put(enc('h0F, 0, 7, 0, 4));
    put(enc('h0D, 0, 0, 0, 0));
    go();
    run(200, cyc);
    chk("call_halt", {63'd0, halt}, 64'd1);
    chk("call_ret_addr", rd64('hFF8), 64'd24);
    chk("call_nout", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      chk("call_out0", out_log[0], 64'hAB);
      chk("call_out1", out_log[1], 64'hCD);
    end

    // store/load with negative offset
    start();
    wr64('h200, 64'h1122_3344_5566_7788);
    put(enc('h12, 5, 0, 0, 'h100));
    put(enc('h10, 7, 0, 0, 'h200));
    put(enc('h13, 5, 7, 0, -8));
    put(enc('h10, 6, 5, 0, -8));
    put(enc('h0F, 0, 6, 0, 4));
    put(enc('h0F, 0, 0, 0, 0));
    go();
    run(200, cyc);
    for (int k = 0; k < 8; k++)
      chk($sformatf("st_byte%0d", k),
          {56'd0, dut.memory.bytes['hF8 + k]},
          64'(8'h88 - 8'(k) * 8'h11));
    chk("ld_back", out_data, 64'h1122_3344_5566_7788);

    // branches: brnz both ways, signed brgt, brr -4 loop
    start();
    put(enc('h12, 2, 0, 0, 1));
    put(enc('h12, 11, 0, 0, 'h11));
    put(enc('h12, 12, 0, 0, 'h22));
    put(enc('h12, 13, 0, 0, 'h33));
    put(enc('h12, 10, 0, 0, 'h28));
    put(enc('h0B, 10, 1, 0, 0));
    put(enc('h0F, 0, 11, 0, 4));
    put(enc('h0B, 10, 2, 0, 0));
    put(enc('h0F, 0, 12, 0, 4));
    put(enc('h0F, 0, 0, 0, 0));
    put(enc('h1B, 3, 0, 0, 1));
    put(enc('h12, 14, 0, 0, 'h3C));
    put(enc('h0E, 14, 3, 2, 0));
    put(enc('h0F, 0, 13, 0, 4));
    put(enc('h12, 15, 0, 0, 'h77));
    put(enc('h0F, 0, 15, 0, 4));
    put(enc('h0A, 0, 0, 0, -4));
    go();
    repeat (110) @(posedge clk);
    #1;
    chk("br_no_halt", {63'd0, halt}, 64'd0);
    chk("br_loop_pulses", 64'(out_log.size() >= 5), 64'd1);
    if (out_log.size() >= 3) begin
      chk("br_seq0", out_log[0], 64'h11);
      chk("br_seq1", out_log[1], 64'h33);
      bad = 0;
      for (int i = 2; i < out_log.size(); i++)
        if (out_log[i] !== 64'h77) bad++;
      chk("br_loop_vals", 64'(bad), 64'd0);
    end

    // asynchronous reset mid-program
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_halt", {63'd0, halt}, 64'd0);
    chk("midrst_pc", dut.pc, 64'd0);

    // input instruction
    start();
    in_data = 64'hDEAD;
    put(enc('h0F, 8, 0, 0, 3));
    put(enc('h0F, 0, 8, 0, 4));
    put(enc('h0F, 0, 0, 0, 0));
    go();
    run(100, cyc);
    chk("input_out", out_data, 64'hDEAD);

    // illegal opcode halts without updating pc
    start();
    put(enc('h12, 1, 0, 0, 1));
    put(enc('h14, 0, 0, 0, 0));
    put(enc('h0F, 0, 1, 0, 4));
    put(enc('h0F, 0, 0, 0, 0));
    go();
    run(100, cyc);
    chk("illegal_halt", {63'd0, halt}, 64'd1);
    chk("illegal_pc", dut.pc, 64'd4);
    chk("illegal_nout", 64'(out_log.size()), 64'd0);

    // data fault: r31-4 runs past the end of memory
    start();
    put(enc('h10, 1, 31, 0, -4));
    put(enc('h0F, 0, 31, 0, 4));
    go();
    run(100, cyc);
    chk("dfault_halt", {63'd0, halt}, 64'd1);
    chk("dfault_pc", dut.pc, 64'd0);
    chk("dfault_nout", 64'(out_log.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
